// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream of fifo_rd_stream.
// master is the stage itself; slave is the FIFO/consumer side.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd;
    logic                  fifo_r_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]  word_cnt;

    modport master (
        input  fifo_empty,
        input  fifo_rd,
        input  out_ready,
        output fifo_r_en,
        output out_valid,
        output out_data,
        output word_cnt
    );

    modport slave (
        output fifo_empty,
        output fifo_rd,
        output out_ready,
        input  fifo_r_en,
        input  out_valid,
        input  out_data,
        input  word_cnt
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side stage behind the synchronous FIFO: absorbs its 1-cycle read
// latency and re-times words into a 2-entry valid/ready skid buffer.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    fifo_rd_stream_if.master   bus
);
    logic [1:0]            cnt;
    logic [1:0]            cnt_next;
    logic [2:0]            occ;
    logic                  inflight;
    logic                  head;
    logic                  tail;
    logic                  head_next;
    logic                  pop_out;
    logic                  capture;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] mem [2];
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_next;
    logic [CNT_WIDTH-1:0]  word_cnt_q;

    assign pop_out = (cnt != 2'd0) & bus.out_ready;
    assign capture = inflight & ~flush;

    // Credit counts the word still in the FIFO read register.
    assign occ  = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop_out};
    assign r_en = rst & ~flush & ~bus.fifo_empty & (occ < 3'd2);

    assign cnt_next  = cnt + {1'b0, capture} - {1'b0, pop_out};
    assign head_next = head ^ pop_out;

    // Registered head: bypass the incoming word when it lands at the head.
    always_comb begin
        data_next = data_q;
        if (cnt_next != 2'd0) begin
            if (capture && (head_next == tail)) begin
                data_next = bus.fifo_rd;
            end else begin
                data_next = mem[head_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            mem[tail] <= bus.fifo_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= 2'd0;
            inflight   <= 1'b0;
            head       <= 1'b0;
            tail       <= 1'b0;
            data_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_q + CNT_WIDTH'(pop_out);
            if (flush) begin
                cnt      <= 2'd0;
                inflight <= 1'b0;
                head     <= 1'b0;
                tail     <= 1'b0;
            end else begin
                cnt      <= cnt_next;
                inflight <= r_en & ~bus.fifo_empty;
                head     <= head_next;
                tail     <= tail ^ capture;
                data_q   <= data_next;
            end
        end
    end

    assign bus.fifo_r_en = r_en;
    assign bus.out_valid = (cnt != 2'd0);
    assign bus.out_data  = data_q;
    assign bus.word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model with 1-cycle read latency and a
// queue-based reference of popped-but-undelivered words.
module tb_fifo_rd_stream;
    localparam int DW = 4;
    localparam int CW = 4;

    typedef struct {
        logic [DW-1:0] d;
        int            avail;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    logic [DW-1:0] fq [$];
    ent_t          mq [$];
    logic [DW-1:0] last_d = '0;
    logic [DW-1:0] pend_d = '0;
    int            wcnt = 0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    bit            pend = 0;
    bit            armed = 0;
    bit            dk = 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    // Called right after a rising edge; returns right after the next one.
    task automatic run_cycle(input bit rdy, input bit fl, input bit rs);
        bit            ev;
        bit            po;
        bit            ren;
        int            occ;
        logic [DW-1:0] ed;
        #1;
        bus.fifo_rd    = pend ? pend_d : DW'($urandom);
        pend           = 0;
        bus.out_ready  = rdy;
        flush          = fl;
        rst            = rs;
        bus.fifo_empty = (fq.size() == 0);
        #1;
        ev  = (mq.size() != 0) && (mq[0].avail <= cyc);
        ed  = ev ? mq[0].d : last_d;
        po  = ev & rdy;
        occ = mq.size() - int'(po);
        ren = rs & !fl & (fq.size() != 0) & (occ < 2);
        if (armed) begin
            chk("out_valid", 32'(bus.out_valid), 32'(ev));
            chk("fifo_r_en", 32'(bus.fifo_r_en), 32'(ren));
            chk("word_cnt", 32'(bus.word_cnt), 32'(wcnt));
            chk("credit", 32'(mq.size() <= 2), 32'd1);
            if (ev || dk) chk("out_data", 32'(bus.out_data), 32'(ed));
        end
        @(posedge clk);
        cyc++;
        if (!rs) begin
            mq.delete();
            last_d = '0;
            wcnt   = 0;
            dk     = 1;
            armed  = 1;
        end else begin
            if (po) begin
                last_d = mq[0].d;
                void'(mq.pop_front());
                wcnt = (wcnt + 1) % (1 << CW);
                dk   = 1;
            end
            if (fl) begin
                if (ev && !po) dk = 0;
                mq.delete();
            end
        end
        if (ren) begin
            pend   = 1;
            pend_d = fq.pop_front();
            mq.push_back('{d: pend_d, avail: cyc + 1});
        end
    endtask

    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_rd    = '0;
        bus.out_ready  = 1'b0;
        fq.push_back(4'hA);
        @(posedge clk);
        run_cycle(1, 0, 0);
        run_cycle(1, 0, 0);
        // single word
        for (int i = 0; i < 5; i++) run_cycle(1, 0, 1);
        chk("single_cnt", 32'(bus.word_cnt), 32'd1);
        // streaming
        for (int i = 1; i <= 4; i++) fq.push_back(DW'(i));
        for (int i = 0; i < 8; i++) run_cycle(1, 0, 1);
        chk("stream_cnt", 32'(bus.word_cnt), 32'd5);
        // backpressure
        for (int i = 5; i <= 8; i++) fq.push_back(DW'(i));
        for (int i = 0; i < 6; i++) run_cycle(0, 0, 1);
        chk("bp_left", 32'(fq.size()), 32'd2);
        for (int i = 0; i < 8; i++) run_cycle(1, 0, 1);
        // flush with a word in flight
        fq.push_back(4'h3);
        fq.push_back(4'h4);
        run_cycle(1, 0, 1);
        run_cycle(1, 1, 1);
        for (int i = 0; i < 6; i++) run_cycle(1, 0, 1);
        chk("flush_cnt", 32'(bus.word_cnt), 32'd10);
        // randomized traffic incl. flush, reset and counter wrap
        for (int i = 0; i < 600; i++) begin
            if (fq.size() < 8 && $urandom_range(0, 99) < 55)
                fq.push_back(DW'($urandom));
            run_cycle($urandom_range(0, 99) < 70,
                      $urandom_range(0, 99) < 4,
                      $urandom_range(0, 99) >= 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
